// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the IF/ID decode stage.
package decode_stage_pkg;

  localparam int unsigned XLEN = 64;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Describes the instruction issued to execute on the previous cycle.
  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic [4:0] rd;
  } ex_tag_t;

endpackage

// File: rtl/decode_stage_rs_usage_decoder.sv
// Combinational opcode decode: which source registers an instruction reads.
module rs_usage_decoder
  import decode_stage_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o
);

  always_comb begin
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    case (opcode_i)
      OP_R, OP_STORE, OP_BRANCH: begin
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        uses_rs1_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// IF/ID pipeline register with field split, load-use hazard stall and branch flush.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     if_instruction,
  input  logic [XLEN-1:0] if_immediate,
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_valid,
  input  logic            flush,
  output logic            stall_if,
  output logic            id_valid,
  output logic            issue_valid,
  output logic [31:0]     id_instruction,
  output logic [XLEN-1:0] id_immediate,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode,
  output logic [4:0]      id_rd,
  output logic [2:0]      id_funct3,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [6:0]      id_funct7,
  output logic [31:0]     stall_count
);

  logic            id_valid_q;
  logic [31:0]     id_instr_q;
  logic [XLEN-1:0] id_imm_q;
  logic [XLEN-1:0] id_pc_q;
  ex_tag_t         tag_q;
  logic [31:0]     stall_count_q;

  logic uses_rs1;
  logic uses_rs2;
  logic rs1_hit;
  logic rs2_hit;
  logic hazard;

  rs_usage_decoder u_rs_usage (
    .opcode_i   (id_instr_q[6:0]),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2)
  );

  assign rs1_hit = uses_rs1 & (id_instr_q[19:15] == tag_q.rd);
  assign rs2_hit = uses_rs2 & (id_instr_q[24:20] == tag_q.rd);
  // Only register state feeds the hazard, so stall_if never depends on fetch inputs.
  assign hazard  = id_valid_q & tag_q.valid & tag_q.is_load & (tag_q.rd != 5'd0) &
                   (rs1_hit | rs2_hit);

  assign stall_if    = hazard & ~flush;
  assign issue_valid = id_valid_q & ~stall_if & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP;
      id_imm_q      <= '0;
      id_pc_q       <= '0;
      tag_q         <= '0;
      stall_count_q <= '0;
    end else if (flush) begin
      id_valid_q  <= 1'b0;
      id_instr_q  <= NOP;
      tag_q.valid <= 1'b0;
    end else if (stall_if) begin
      // Hold ID and send a bubble; clearing the tag guarantees a one-cycle stall.
      tag_q.valid   <= 1'b0;
      stall_count_q <= stall_count_q + 32'd1;
    end else begin
      id_valid_q    <= if_valid;
      id_instr_q    <= if_valid ? if_instruction : NOP;
      id_imm_q      <= if_immediate;
      id_pc_q       <= if_pc;
      tag_q.valid   <= id_valid_q;
      tag_q.is_load <= (id_instr_q[6:0] == OP_LOAD);
      tag_q.rd      <= id_instr_q[11:7];
    end
  end

  assign id_valid       = id_valid_q;
  assign id_instruction = id_instr_q;
  assign id_immediate   = id_imm_q;
  assign id_pc          = id_pc_q;
  assign id_opcode      = id_instr_q[6:0];
  assign id_rd          = id_instr_q[11:7];
  assign id_funct3      = id_instr_q[14:12];
  assign id_rs1         = id_instr_q[19:15];
  assign id_rs2         = id_instr_q[24:20];
  assign id_funct7      = id_instr_q[31:25];
  assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios followed by random traffic.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     if_instruction = NOP;
  logic [XLEN-1:0] if_immediate = '0;
  logic [XLEN-1:0] if_pc = '0;
  logic            if_valid = 1'b0;
  logic            flush = 1'b0;
  logic            stall_if, id_valid, issue_valid;
  logic [31:0]     id_instruction, stall_count;
  logic [XLEN-1:0] id_immediate, id_pc;
  logic [6:0]      id_opcode, id_funct7;
  logic [4:0]      id_rd, id_rs1, id_rs2;
  logic [2:0]      id_funct3;

  decode_stage dut (
    .clk            (clk),
    .reset          (reset),
    .if_instruction (if_instruction),
    .if_immediate   (if_immediate),
    .if_pc          (if_pc),
    .if_valid       (if_valid),
    .flush          (flush),
    .stall_if       (stall_if),
    .id_valid       (id_valid),
    .issue_valid    (issue_valid),
    .id_instruction (id_instruction),
    .id_immediate   (id_immediate),
    .id_pc          (id_pc),
    .id_opcode      (id_opcode),
    .id_rd          (id_rd),
    .id_funct3      (id_funct3),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_funct7      (id_funct7),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        issue;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] count;
  } cyc_t;

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } iss_t;

  cyc_t cyc_q[$];
  iss_t iss_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference state: what sits in decode and what was last handed to execute.
  bit              m_known = 0;
  logic            m_valid;
  logic [31:0]     m_instr;
  logic [XLEN-1:0] m_imm, m_pc;
  logic            last_valid, last_load;
  logic [4:0]      last_rd;
  logic [31:0]     m_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which sources an opcode reads, straight from the opcode table.
  function automatic logic [1:0] reads(input logic [6:0] op);
    if (op inside {7'b0110011, 7'b0100011, 7'b1100011}) return 2'b11;
    if (op inside {7'b0010011, 7'b0000011, 7'b1100111}) return 2'b10;
    return 2'b00;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [63:0] imm, input logic [63:0] pc,
                       input logic v, input logic fl, input logic rst, input bit frc = 0);
    logic [1:0] u;
    logic       hz, st, iss;
    @(negedge clk);
    if_instruction = ins;
    if_immediate   = imm;
    if_pc          = pc;
    if_valid       = v;
    flush          = fl;
    reset          = rst;
    if (frc) begin
      force dut.stall_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_count_q;
      m_count = 32'hFFFF_FFFF;
    end
    if (m_known) begin
      u   = reads(m_instr[6:0]);
      hz  = m_valid && last_valid && last_load && last_rd != 5'd0 &&
            ((u[1] && m_instr[19:15] == last_rd) || (u[0] && m_instr[24:20] == last_rd));
      st  = hz && !fl;
      iss = m_valid && !st && !fl;
      cyc_q.push_back('{stall: st, issue: iss, valid: m_valid, instr: m_instr, count: m_count});
      if (iss) iss_q.push_back('{instr: m_instr, imm: m_imm, pc: m_pc});
    end else begin
      st = 1'b0;
    end
    if (rst) begin
      m_valid = 0; m_instr = NOP; m_imm = '0; m_pc = '0;
      last_valid = 0; last_load = 0; last_rd = '0; m_count = '0;
      m_known = 1;
    end else if (m_known) begin
      if (fl) begin
        m_valid = 0; m_instr = NOP; last_valid = 0;
      end else if (st) begin
        last_valid = 0;
        m_count    = m_count + 1;
      end else begin
        last_valid = m_valid;
        last_load  = (m_instr[6:0] == 7'b0000011);
        last_rd    = m_instr[11:7];
        m_valid    = v;
        m_instr    = v ? ins : NOP;
        m_imm      = imm;
        m_pc       = pc;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(NOP, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [31:0] ins, input logic [63:0] pc);
    drive(ins, {$urandom, $urandom}, pc, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: samples well after the falling edge, when inputs and outputs have settled.
  initial begin
    cyc_t c;
    iss_t e;
    forever begin
      @(negedge clk);
      #2;
      if (cyc_q.size() != 0) begin
        c = cyc_q.pop_front();
        check("stall_if", 64'(stall_if), 64'(c.stall));
        check("issue_valid", 64'(issue_valid), 64'(c.issue));
        check("id_valid", 64'(id_valid), 64'(c.valid));
        check("id_instruction", 64'(id_instruction), 64'(c.instr));
        check("stall_count", 64'(stall_count), 64'(c.count));
      end
      if (issue_valid) begin
        if (iss_q.size() == 0) begin
          check("unexpected_issue", 64'(1), 64'(0));
        end else begin
          e = iss_q.pop_front();
          check("iss_instruction", 64'(id_instruction), 64'(e.instr));
          check("iss_immediate", id_immediate, e.imm);
          check("iss_pc", id_pc, e.pc);
          check("iss_opcode", 64'(id_opcode), 64'(e.instr & 32'h7F));
          check("iss_rd", 64'(id_rd), 64'((e.instr >> 7) & 32'h1F));
          check("iss_funct3", 64'(id_funct3), 64'((e.instr >> 12) & 32'h7));
          check("iss_rs1", 64'(id_rs1), 64'((e.instr >> 15) & 32'h1F));
          check("iss_rs2", 64'(id_rs2), 64'((e.instr >> 20) & 32'h1F));
          check("iss_funct7", 64'(id_funct7), 64'(e.instr >> 25));
        end
      end
    end
  end

  localparam logic [31:0] LD_X3   = 32'h0000_B183;
  localparam logic [31:0] ADD_X4  = 32'h0031_8233;
  localparam logic [31:0] LD_X0   = 32'h0000_B003;
  localparam logic [31:0] ADD_X00 = 32'h0000_0233;
  localparam logic [31:0] LUI_X3  = 32'h0000_11B7;

  initial begin
    logic [6:0] ops [9];
    logic [31:0] ins;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    drive(NOP, '0, '0, 1'b0, 1'b0, 1'b1);
    drive(NOP, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(1);

    send(32'h0020_8133, 64'h40);
    idle(2);

    send(LD_X3, 64'h100);
    send(ADD_X4, 64'h104);
    idle(3);

    send(LD_X0, 64'h200);
    send(ADD_X00, 64'h204);
    idle(2);
    send(LD_X3, 64'h300);
    send(LUI_X3, 64'h304);
    idle(2);

    send(LD_X3, 64'h400);
    send(ADD_X4, 64'h404);
    drive(NOP, '0, '0, 1'b0, 1'b1, 1'b0);
    idle(2);

    drive(NOP, '0, '0, 1'b0, 1'b0, 1'b0, 1);
    send(LD_X3, 64'h500);
    send(ADD_X4, 64'h504);
    idle(3);

    send(LD_X3, 64'h600);
    send(ADD_X4, 64'h604);
    drive(NOP, '0, '0, 1'b0, 1'b1, 1'b1);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      ins = {$urandom_range(127, 0), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
             3'($urandom_range(7, 0)), 5'($urandom_range(3, 0)), ops[$urandom_range(8, 0)]};
      drive(ins, {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(99, 0) < 85), ($urandom_range(99, 0) < 8),
            ($urandom_range(999, 0) < 5));
    end
    idle(3);
    @(negedge clk);
    #4;
    check("leftover_issues", 64'(iss_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

IF/ID pipeline stage sitting directly downstream of the fetch block. It latches the fetched instruction, its immediate and its PC, and splits the instruction into register/opcode fields for the execute stage. It also detects load-use hazards against the instruction it issued on the previous cycle. On a hazard it stalls fetch for one cycle and issues a bubble; a branch flush kills the latched instruction.

## Interface
- XLEN, 64, datapath width of PC and immediate
- NOP, 32'h00000013, instruction word held when the stage is empty (addi x0,x0,0)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- if_instruction  in  32  instruction word from fetch
- if_immediate  in  XLEN  immediate from fetch's immediate generator
- if_pc  in  XLEN  address of if_instruction
- if_valid  in  1  fetch outputs are meaningful this cycle
- flush  in  1  taken branch; discard the ID contents
- stall_if  out  1  combinational; when high, fetch must hold the PC (drive PC load low)
- id_valid  out  1  ID register holds a live instruction
- issue_valid  out  1  id_valid & ~stall_if & ~flush; execute consumes id_* only when high
- id_instruction  out  32  latched instruction
- id_immediate  out  XLEN  latched immediate
- id_pc  out  XLEN  latched PC
- id_opcode  out  7  id_instruction[6:0]
- id_rd  out  5  id_instruction[11:7]
- id_funct3  out  3  id_instruction[14:12]
- id_rs1  out  5  id_instruction[19:15]
- id_rs2  out  5  id_instruction[24:20]
- id_funct7  out  7  id_instruction[31:25]
- stall_count  out  32  number of load-use stall cycles since reset

## Operation
- **Stage registers.** The block has an ID register {valid, instruction, immediate, pc} and an EX tag {valid, is_load, rd} describing the last issued instruction.
- **Source register use by opcode.**
  - rs1 and rs2: 0110011, 0100011, 1100011.
  - rs1 only: 0010011, 0000011, 1100111.
  - None: all other opcodes, including 0110111, 0010111 and 1101111.
- **Hazard condition.** hazard = id_valid & tag.valid & tag.is_load & (tag.rd != 0) & ((uses_rs1 & id_rs1 == tag.rd) | (uses_rs2 & id_rs2 == tag.rd)).
- **stall_if** = hazard & ~flush.
- **Per rising edge, in priority order:**
  1. reset: ID gets valid 0, instruction NOP, immediate 0, pc 0. EX tag valid 0, is_load 0, rd 0. stall_count 0.
  2. flush: ID gets valid 0 and instruction NOP. EX tag gets valid 0. Fetch inputs are ignored this cycle.
  3. stall_if: ID holds its contents. EX tag gets valid 0 (bubble). stall_count increments.
  4. Otherwise: ID is loaded from the fetch inputs with valid = if_valid; when if_valid is 0, instruction is NOP. EX tag is loaded from the ID contents: valid = id_valid, is_load = (id_opcode == 0000011), rd = id_rd.
- **stall_count.** Wraps from 32'hFFFFFFFF to 0.
- **Decoded fields.** All fields are pure slices of id_instruction. After reset they decode NOP.

## Timing
- Latency: fetch inputs valid at cycle n appear on id_* after edge n+1, and issue in the same cycle unless a stall or flush occurs.
- A load-use stall lasts exactly one cycle. The bubble clears tag.valid, so the hazard cannot persist.
- stall_if, issue_valid and the decoded fields are combinational from registers and flush. They have no dependency on fetch inputs, so there is no combinational loop through the PC.
- Flush and hazard in the same cycle: flush wins. stall_if stays 0 and stall_count does not increment.
- Reset asserted mid-stall or mid-flush: reset wins. All outputs return to reset values on that edge.
- rd = x0 never causes a hazard.

## Structure
- Shared package: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), NOP, XLEN.
- One sub-module: rs_usage_decoder (opcode -> uses_rs1, uses_rs2), which is combinational.
- The ID register, the EX tag and the counter live in decode_stage itself.

## Test plan
- **Reset.** Assert reset for 2 cycles. Required: id_valid=0, id_instruction=32'h00000013, issue_valid=0, stall_if=0, stall_count=0.
- **Pass-through.** Present if_instruction=32'h00208133 (add x2,x1,x2), if_pc=64'h40, if_valid=1. Next cycle required: id_rd=2, id_rs1=1, id_rs2=2, id_pc=64'h40, issue_valid=1.
- **Load-use.** Issue 32'h0000B183 (ld x3,0(x1)), then 32'h00318233 (add x4,x3,x3). Required on the add's ID cycle: stall_if=1 and issue_valid=0 for exactly 1 cycle. Then the add issues, and stall_count=1.
- **No false stall.**
  - ld x0,0(x1), then add x4,x0,x0: stall_if stays 0.
  - ld x3, then lui x3,0x1 (32'h000011B7): stall_if stays 0.
- **Flush vs hazard.** Set up the load-use pair and assert flush in the stall cycle. Required: stall_if=0, next cycle id_valid=0, stall_count unchanged.
- **Counter wrap.** Force stall_count to 32'hFFFFFFFF, then trigger one load-use stall. Required: stall_count=0.
